// File: rtl/multicycle_control_fsm_if.sv
// Handshake bundle between the multi-cycle controller and its instruction/data memories.
interface multicycle_control_fsm_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_read;
  logic dmem_write;
  logic dmem_ready;

  modport master (output imem_req, dmem_read, dmem_write, input imem_ready, dmem_ready);
  modport slave  (input imem_req, dmem_read, dmem_write, output imem_ready, dmem_ready);
endinterface

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV64I datapath: FETCH/DECODE/EXECUTE/MEM/WB with
// memory handshakes, illegal-opcode and memory-timeout traps, and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [6:0]               opcode,
  input  logic                     zero,
  multicycle_control_fsm_if.master mem,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     pc_src,
  output logic                     alu_src,
  output logic [1:0]               alu_op,
  output logic                     mem_to_reg,
  output logic                     reg_write,
  output logic [2:0]               state,
  output logic                     illegal_instr,
  output logic                     timeout,
  output logic [CNT_W-1:0]         instr_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    TRAP    = 3'd6
  } state_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_read;
    logic       dmem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } strobes_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  strobes_t   strb_q;
  logic [7:0] wait_q;
  logic       is_r, is_i, is_ld, is_sd, is_beq, legal;
  logic       wait_hit, retire, sd_done, mem_trap;

  assign is_r     = opcode == OP_R;
  assign is_i     = opcode == OP_I;
  assign is_ld    = opcode == OP_LD;
  assign is_sd    = opcode == OP_SD;
  assign is_beq   = opcode == OP_BEQ;
  assign legal    = is_r | is_i | is_ld | is_sd | is_beq;
  assign wait_hit = wait_q == WAIT_LIMIT;
  assign sd_done  = (state_q == MEM) && is_sd && mem.dmem_ready;

  // Strobes each state presents; registered one cycle ahead from the next state.
  function automatic strobes_t decode_strobes(input state_t s, input logic [6:0] op);
    strobes_t s_out;
    s_out = '0;
    case (s)
      FETCH: s_out.imem_req = 1'b1;
      EXECUTE, MEM, WB: begin
        s_out.alu_src = (op == OP_I) || (op == OP_LD) || (op == OP_SD);
        if (op == OP_BEQ)                     s_out.alu_op = 2'b01;
        else if ((op == OP_LD) || (op == OP_SD)) s_out.alu_op = 2'b00;
        else                                  s_out.alu_op = 2'b10;
        if (s == EXECUTE) s_out.pc_write = op == OP_BEQ;
        if (s == MEM) begin
          s_out.dmem_read  = op == OP_LD;
          s_out.dmem_write = op == OP_SD;
        end
        if (s == WB) begin
          s_out.reg_write  = 1'b1;
          s_out.mem_to_reg = op == OP_LD;
          s_out.pc_write   = 1'b1;
        end
      end
      default: ;
    endcase
    return s_out;
  endfunction

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d  = state_q;
    retire   = 1'b0;
    mem_trap = 1'b0;
    case (state_q)
      IDLE:    if (run) state_d = FETCH;
      FETCH: begin
        if (mem.imem_ready) state_d = DECODE;
        else if (wait_hit) begin
          state_d  = TRAP;
          mem_trap = 1'b1;
        end
      end
      DECODE:  state_d = legal ? EXECUTE : TRAP;
      EXECUTE: begin
        if (is_beq)             retire  = 1'b1;
        else if (is_ld | is_sd) state_d = MEM;
        else                    state_d = WB;
      end
      MEM: begin
        if (mem.dmem_ready) begin
          if (is_ld) state_d = WB;
          else       retire  = 1'b1;
        end else if (wait_hit) begin
          state_d  = TRAP;
          mem_trap = 1'b1;
        end
      end
      WB:      retire = 1'b1;
      TRAP:    ;
      default: state_d = IDLE;
    endcase
    // A finished instruction always completes; run only decides where the next one starts.
    if (retire) state_d = run ? FETCH : IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      strb_q        <= '0;
      wait_q        <= '0;
      illegal_instr <= 1'b0;
      timeout       <= 1'b0;
      instr_count   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state_q <= state_d;
      strb_q  <= decode_strobes(state_d, opcode);
      wait_q  <= ((state_d == state_q) && ((state_q == FETCH) || (state_q == MEM)))
                 ? wait_q + 8'd1 : '0;
      if ((state_q == DECODE) && !legal) illegal_instr <= 1'b1;
      if (mem_trap)                      timeout       <= 1'b1;
      if (retire)                        instr_count   <= instr_count + CNT_W'(1);
    end
  end

  // Ready- and flag-qualified strobes must act in the very cycle the condition appears.
  assign ir_write       = (state_q == FETCH) && mem.imem_ready;
  assign pc_src         = (state_q == EXECUTE) && is_beq && zero;
  assign pc_write       = strb_q.pc_write | sd_done;
  assign mem.imem_req   = strb_q.imem_req;
  assign mem.dmem_read  = strb_q.dmem_read;
  assign mem.dmem_write = strb_q.dmem_write;
  assign alu_src        = strb_q.alu_src;
  assign alu_op         = strb_q.alu_op;
  assign mem_to_reg     = strb_q.mem_to_reg;
  assign reg_write      = strb_q.reg_write;
  assign state          = state_q;

endmodule
